// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the dot-product MAC sequencer.
//   state_e    - sequencer FSM encoding (DRAIN is reachable only when the
//                MAC_PIPE_EN build option is defined).
//   *_DEF      - default operand, accumulator and length widths.
package mac_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;
   localparam int LEN_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/mac_acc_core.sv
// mac_acc_core: unsigned DATA_W x DATA_W multiplier feeding an ACC_W
// wrapping accumulator.
// Build option: MAC_PIPE_EN inserts a register (product + valid) between the
// multiplier and the adder, so an accepted pair is added one cycle later.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   en         accept a/b this cycle
//   clr        clear the accumulator (wins over any add)
//   a, b       operands
//   acc        accumulator value including the product being added this cycle
//   carry      carry-out of the add performed this cycle (0 when no add)
module mac_acc_core #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic              carry
);

   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    addend;
   logic                add_en;
   logic [ACC_W-1:0]    sum;
   logic                carry_raw;
   logic [ACC_W-1:0]    acc_q, acc_d;

   assign prod = a * b;

`ifdef MAC_PIPE_EN
   logic [2*DATA_W-1:0] prod_q, prod_d;
   logic                pv_q, pv_d;

   always_comb begin
      prod_d = prod;
      pv_d   = en;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q <= '0;
         pv_q   <= 1'b0;
      end else begin
         prod_q <= prod_d;
         pv_q   <= pv_d;
      end
   end

   assign addend = ACC_W'(prod_q);
   assign add_en = pv_q;
`else
   assign addend = ACC_W'(prod);
   assign add_en = en;
`endif

   // One extra bit on the add exposes the carry-out; the stored value wraps.
   assign {carry_raw, sum} = {1'b0, acc_q} + {1'b0, addend};
   assign acc   = sum;
   assign carry = add_en & carry_raw;

   always_comb begin
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (add_en)
         acc_d = sum;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

endmodule

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: runs one dot product of programmable length through
// mac_acc_core and returns the result on a valid/ready port.
// Build option: MAC_PIPE_EN selects the pipelined core; RUN then leaves through
// a one-cycle DRAIN state so the last product is retired before DONE.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, len         command strobe and pair count (sampled only in IDLE)
//   busy               high whenever the FSM is not IDLE
//   in_valid/in_ready  operand-pair stream, in_a/in_b carried with it
//   res_valid/res_ready result port, res_data (mod 2^ACC_W) and res_ovf
//   dbg_state          current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload until that edge, and ready never
// depends combinationally on valid (in_ready and res_valid decode state only).
module mac_dot_sequencer
   import mac_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_ovf,
   output state_e            dbg_state
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] res_data_q, res_data_d;
   logic             res_ovf_q, res_ovf_d;
   logic             beat;
   logic             clr;
   logic [ACC_W-1:0] acc;
   logic             carry;

   assign beat = in_valid & in_ready;

   mac_acc_core #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .en    (beat),
      .clr   (clr),
      .a     (in_a),
      .b     (in_b),
      .acc   (acc),
      .carry (carry)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Control/datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
      end else begin
         count_q    <= count_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         res_data_q <= res_data_d;
         res_ovf_q  <= res_ovf_d;
      end
   end

   // Next state. count only reaches len-1 (at most 2^LEN_W-2), so it cannot
   // wrap even for the maximum length.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      len_d      = len_q;
      ovf_d      = ovf_q | carry;
      res_data_d = res_data_q;
      res_ovf_d  = res_ovf_q;
      clr        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  clr     = 1'b1;
                  ovf_d   = 1'b0;
                  len_d   = len;
                  count_d = '0;
                  state_d = RUN;
               end else begin
                  res_data_d = '0;
                  res_ovf_d  = 1'b0;
                  state_d    = DONE;
               end
            end
         end
         RUN: begin
            if (beat) begin
               if (count_q == len_q - LEN_W'(1)) begin
                  count_d = '0;
`ifdef MAC_PIPE_EN
                  state_d = DRAIN;
`else
                  res_data_d = acc;
                  res_ovf_d  = ovf_q | carry;
                  state_d    = DONE;
`endif
               end else begin
                  count_d = count_q + LEN_W'(1);
               end
            end
         end
         DRAIN: begin
            // The registered final product is being added this cycle.
            res_data_d = acc;
            res_ovf_d  = ovf_q | carry;
            state_d    = DONE;
         end
         DONE: begin
            if (res_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode from state only.
   always_comb begin
      busy      = (state_q != IDLE);
      in_ready  = (state_q == RUN);
      res_valid = (state_q == DONE);
      res_data  = res_data_q;
      res_ovf   = res_ovf_q;
      dbg_state = state_q;
   end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Controller that sequences the team's 8x8 multiply / 16-bit accumulate datapath through one dot product of programmable length.
- Accepts a start command with a vector length, then pulls operand pairs over a valid/ready stream.
- Accumulates the products from a cleared accumulator and presents one result on a valid/ready output port.
- Sits between the operand fetch logic and the consumer of MAC results. Replaces the free-running, reset-only-cleared accumulation of the current MAC.

Parameters:
- DATA_W, 8, operand width (unsigned).
- ACC_W, 16, accumulator/result width; must be >= 2*DATA_W.
- LEN_W, 8, width of the vector-length field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts an operand pair.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  ACC_W  dot-product result, modulo 2^ACC_W.
- res_ovf  out  1  sticky: a carry-out occurred during this dot product.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, accumulator=0, count=0, busy=0, in_ready=0, res_valid=0, res_data=0, res_ovf=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: clear accumulator and ovf, latch len, count=0, go to RUN.
  - start=1 with len==0: res_data=0, res_ovf=0, go to DONE.
- RUN:
  - in_ready=1 (combinational from state).
  - Each cycle with in_valid & in_ready: acc <= acc + in_a*in_b, unsigned; the product is zero-extended to ACC_W.
  - The carry-out of each add is ORed into ovf. The accumulator wraps.
  - count increments on each beat. On the beat with count==len-1: update acc, go to DONE, copy acc+product to res_data.
  - A valid-low cycle stalls with no state change.
- DONE:
  - res_valid=1; res_data and res_ovf held stable; in_ready=0.
  - res_ready=1: res_valid drops next cycle, go to IDLE.
  - start is ignored in RUN and DONE.
  - A start in the same cycle as the DONE->IDLE transition is ignored; it is accepted on the next cycle.
- Latency: res_valid rises on the first cycle after the last accepted beat.
  - Back-to-back operation: N-beat command takes N cycles in RUN, plus at least 1 in DONE, plus 1 in IDLE.
- Reset mid-operation: all state is discarded immediately; the partial accumulation is lost and no result is produced.
- len=2^LEN_W-1 (255 by default) is the maximum; count must not overflow.

Optional Feature:
- Macro: MAC_PIPE_EN.
- When defined:
  - A pipeline register sits between the multiplier and the adder, registering product and valid.
  - RUN exits via an extra state, DRAIN, after the last beat. DRAIN lasts 1 cycle to retire the final product, then goes to DONE.
  - Result latency is 2 cycles after the last beat; beat throughput is unchanged, at 1 per cycle.
- When undefined: the multiply and add are single-cycle and there is no DRAIN state.
- Results are bit-identical either way.

Decomposition:
- Shared package, mac_pkg:
  - state enum (IDLE, RUN, DONE, DRAIN);
  - default DATA_W/ACC_W/LEN_W constants.
- Sub-module mac_acc_core:
  - DATA_W multiplier plus ACC_W adder with accumulator;
  - inputs en, clr; outputs acc and carry.
  - The sequencer owns all control, count and handshakes.

Test Plan:
- len=3; pairs (2,3), (4,5), (10,10) with in_valid held high -> res_valid on the cycle after the 3rd beat; res_data=0x007E (126), res_ovf=0.
- len=2; in_valid toggled 1,0,0,1 -> exactly 2 beats accepted; in_ready high throughout RUN; result equals a0*b0+a1*b1.
- len=2; pairs (255,255), (255,255) -> res_data=0xFC02 (130050 mod 65536), res_ovf=1.
- len=0 -> DONE without any in_ready; res_data=0; start asserted again while res_valid=1 with res_ready=0 is ignored, and res_data stays stable.
- len=4; assert rst=0 after 2 beats -> all outputs return to reset values the same cycle. A following len=1 command with (7,6) yields res_data=42, with no residue from the aborted run.
- With and without MAC_PIPE_EN, random len 1..255 and random operands -> res_data matches a software model; latency is 1 or 2 cycles respectively.
